seq_divider: RTL and testbench
==============================

// Module: seq_divider
// PURPOSE
//   Sequential restoring divider: 2N-bit dividend / N-bit divisor -> 2N-bit quotient + N-bit remainder.
//   Inverse datapath of the team's 4x4 array multiplier: an 8-bit product divided by one 4-bit factor
//   returns the other factor with remainder 0. Uses one shift/subtract per cycle, so area stays small.
//   Controlled by a start/busy/done handshake.
// PARAMETERS
//   N  default 4  divisor/remainder width; dividend and quotient are 2N bits; iteration count = 2N
// PORTS
//   clk          input   1     rising-edge clock
//   rst          input   1     synchronous, active-high reset
//   start        input   1     request; sampled only in IDLE or DONE
//   dividend     input   2N    captured on accepted start
//   divisor      input   N     captured on accepted start
//   busy         output  1     high while in CALC
//   done         output  1     one-cycle pulse; quotient/remainder/div_by_zero are valid from that cycle
//   quotient     output  2N    result, held until next accepted start
//   remainder    output  N     result, held until next accepted start
//   div_by_zero  output  1     set with done when divisor == 0; held with results
// BEHAVIOUR
//   Reset: state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; iteration counter=0.
//   rst dominates every other input in every state, including mid-CALC; a partial result is discarded.
//   FSM states IDLE, CALC, DONE:
//     IDLE/DONE, start=1, divisor!=0 -> CALC
//       - capture operands; partial remainder R (N+1 bits) = 0; Q = dividend; counter = 2N.
//     IDLE/DONE, start=1, divisor==0 -> DONE (next cycle)
//       - quotient = {2N{1'b1}}, remainder = dividend[N-1:0], div_by_zero = 1; no CALC cycles.
//     IDLE, start=0 -> IDLE.   DONE, start=0 -> IDLE.   Outputs hold in both cases.
//     CALC, each cycle (one iteration):
//       - T = {R[N-1:0], Q[2N-1]}; Q = Q << 1.
//       - if T >= {1'b0,divisor}: R = T - divisor and Q[0] = 1; else R = T and Q[0] = 0.
//       - counter decrements; the cycle in which counter goes 1->0 moves to DONE.
//     DONE: done=1 for exactly this cycle; quotient=Q, remainder=R[N-1:0], div_by_zero=0.
//   start in CALC is ignored: no restart and no queuing. busy=1 in every CALC cycle only.
//   start in the DONE cycle is accepted: back-to-back operation, with DONE->CALC directly.
//   Latency, start sampled at edge k:
//     - divisor!=0: busy over edges k+1..k+2N; done high after edge k+2N+1, i.e. 2N+1 cycles (9 for N=4).
//     - divisor==0: done high after edge k+1.
//   Width rules:
//     - T and the compare are N+1 bits, so no overflow is possible.
//     - quotient is never truncated: 2N bits cover divisor=1.
//   Results (quotient/remainder) change only on entry to DONE; they are stable in all other states.
//   div_by_zero is cleared on any accepted start with divisor!=0.
// TESTING
//   1) dividend=8'd143, divisor=4'd11, start 1 cycle -> busy 8 cycles, done 9 cycles after start; Q=13, R=0.
//   2) 100/7 -> Q=14, R=2.   255/1 -> Q=255, R=0.   0/9 -> Q=0, R=0.   15/15 -> Q=1, R=0.
//   3) dividend=8'h3C, divisor=0 -> done 1 cycle later, Q=8'hFF, R=4'hC, div_by_zero=1, busy never high.
//   4) start held high through CALC with changing operands -> first result unaffected.
//      Then start in DONE cycle with 200/3 -> no IDLE cycle, next result Q=66, R=2.
//   5) rst asserted on 4th CALC cycle -> next cycle: IDLE and all outputs 0.
//      New start after reset then gives a correct result.
//   6) Round trip: for all a,b in 1..15, divide a*b by b -> Q=a, R=0, div_by_zero=0.
//      Also random dividend/divisor vs a reference model (/ and %).

Source files
------------

// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bundle for the sequential divider.
// The slave side belongs to the divider; the master side to whoever issues divisions.
interface seq_divider_if #(
    parameter int N = 4
);
    logic           start;
    logic [2*N-1:0] dividend;
    logic [N-1:0]   divisor;
    logic           busy;
    logic           done;
    logic [2*N-1:0] quotient;
    logic [N-1:0]   remainder;
    logic           div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one shift/subtract per cycle: 2N-bit dividend / N-bit divisor
// gives a 2N-bit quotient and N-bit remainder after 2N CALC cycles.
module seq_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = $clog2(2 * N + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t         state_q,  state_d;
    logic [N-1:0]   rem_part_q, rem_part_d;
    logic [2*N-1:0] shift_q,  shift_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [N-1:0]   dvs_q,    dvs_d;
    logic [2*N-1:0] quot_q,   quot_d;
    logic [N-1:0]   rem_q,    rem_d;
    logic           dbz_q,    dbz_d;

    logic [N:0]     trial;
    logic [N:0]     diff;
    logic           fits;
    logic [N-1:0]   rem_step;
    logic [2*N-1:0] shift_step;

    // The partial remainder is always below the divisor, so trial < 2*divisor and
    // trial - divisor lies in (-2^N, 2^N): its top bit is a clean borrow flag.
    // That same invariant keeps the stored partial remainder at N bits.
    assign trial      = {rem_part_q, shift_q[2*N-1]};
    assign diff       = trial - {1'b0, dvs_q};
    assign fits       = ~diff[N];
    assign rem_step   = fits ? diff[N-1:0] : trial[N-1:0];
    assign shift_step = {shift_q[2*N-2:0], fits};

    always_comb begin
        state_d    = state_q;
        rem_part_d = rem_part_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        dvs_d      = dvs_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        dbz_d      = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        state_d = S_DONE;
                        quot_d  = '1;
                        rem_d   = bus.dividend[N-1:0];
                        dbz_d   = 1'b1;
                    end else begin
                        state_d    = S_CALC;
                        dvs_d      = bus.divisor;
                        rem_part_d = '0;
                        shift_d    = bus.dividend;
                        cnt_d      = CW'(2 * N);
                        dbz_d      = 1'b0;
                    end
                end
            end

            S_CALC: begin
                rem_part_d = rem_step;
                shift_d    = shift_step;
                cnt_d      = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_DONE;
                    quot_d  = shift_step;
                    rem_d   = rem_step;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rem_part_q <= '0;
            shift_q    <= '0;
            cnt_q      <= '0;
            dvs_q      <= '0;
            quot_q     <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_part_q <= rem_part_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            dvs_q      <= dvs_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            dbz_q      <= dbz_d;
        end
    end

    assign bus.busy        = (state_q == S_CALC);
    assign bus.done        = (state_q == S_DONE);
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against a plain / and % reference.
module tb_seq_divider;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_if #(.N(N)) bus ();
    seq_divider #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] held_q = '0;
    logic [N-1:0]   held_r = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Steps edges until done (bounded), counting busy cycles and checking that
    // the previous result stays put while the divider works.
    task automatic wait_done(input bit hold, output int n, output int nbusy);
        n = 0;
        nbusy = 0;
        do begin
            tick();
            n++;
            if (hold) begin
                bus.dividend = 8'($urandom);
                bus.divisor  = 4'($urandom);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.busy === 1'b1) begin
                nbusy++;
                check("held_q", 32'(bus.quotient), 32'(held_q));
                check("held_r", 32'(bus.remainder), 32'(held_r));
            end
        end while (bus.done !== 1'b1 && n < 40);
    endtask

    task automatic check_result(input string tag, input int a, input int b, input int n, input int nbusy);
        int eq, er, ez, elat, ebusy;
        if (b == 0) begin
            eq = 255; er = a % 16; ez = 1; elat = 1; ebusy = 0;
        end else begin
            eq = a / b; er = a % b; ez = 0; elat = 2 * N + 1; ebusy = 2 * N;
        end
        check({tag, "_latency"}, n, elat);
        check({tag, "_busy_cycles"}, nbusy, ebusy);
        check({tag, "_done"}, 32'(bus.done), 1);
        check({tag, "_q"}, 32'(bus.quotient), eq);
        check({tag, "_r"}, 32'(bus.remainder), er);
        check({tag, "_dbz"}, 32'(bus.div_by_zero), ez);
        $display("div %0d / %0d -> q=%0d r=%0d dbz=%0d latency=%0d", a, b,
                 bus.quotient, bus.remainder, bus.div_by_zero, n);
        held_q = 8'(eq);
        held_r = 4'(er);
    endtask

    task automatic run_div(input string tag, input int a, input int b);
        int n, nbusy;
        bus.dividend = 8'(a);
        bus.divisor  = 4'(b);
        bus.start    = 1'b1;
        wait_done(1'b0, n, nbusy);
        check_result(tag, a, b, n, nbusy);
    endtask

    initial begin
        int n, nbusy, a, b;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.dividend = '0;
        bus.divisor = '0;
        tick();
        tick();
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_q", 32'(bus.quotient), 0);
        check("rst_r", 32'(bus.remainder), 0);
        check("rst_dbz", 32'(bus.div_by_zero), 0);
        rst = 1'b0;
        tick();

        // Basic division and done-pulse width / result hold afterwards
        run_div("t143_11", 143, 11);
        tick();
        check("pulse_done", 32'(bus.done), 0);
        check("pulse_busy", 32'(bus.busy), 0);
        check("hold_q", 32'(bus.quotient), 13);
        tick();
        check("idle_hold_r", 32'(bus.remainder), 0);

        run_div("t100_7", 100, 7);
        run_div("t255_1", 255, 1);
        run_div("t0_9", 0, 9);
        run_div("t15_15", 15, 15);

        // Divide by zero, then a normal division must clear the flag
        run_div("t3c_0", 60, 0);
        tick();
        check("dbz_hold", 32'(bus.div_by_zero), 1);
        run_div("t15_15b", 15, 15);

        // start held through CALC with scrambled operands, then back-to-back from DONE
        bus.dividend = 8'd143;
        bus.divisor  = 4'd11;
        bus.start    = 1'b1;
        wait_done(1'b1, n, nbusy);
        check_result("held_start", 143, 11, n, nbusy);
        run_div("b2b_200_3", 200, 3);

        // Reset in the 4th CALC cycle
        bus.dividend = 8'd143;
        bus.divisor  = 4'd11;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        check("mid_busy", 32'(bus.busy), 1);
        tick();
        tick();
        tick();
        check("mid_busy4", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 32'(bus.busy), 0);
        check("midrst_done", 32'(bus.done), 0);
        check("midrst_q", 32'(bus.quotient), 0);
        check("midrst_r", 32'(bus.remainder), 0);
        check("midrst_dbz", 32'(bus.div_by_zero), 0);
        tick();
        check("midrst_idle", 32'(bus.busy | bus.done), 0);
        held_q = '0;
        held_r = '0;
        run_div("after_rst", 143, 11);

        // Round trip against the multiplier: (a*b)/b == a
        for (int ai = 1; ai <= 15; ai++) begin
            for (int bi = 1; bi <= 15; bi++) begin
                run_div("roundtrip", ai * bi, bi);
            end
        end

        // Random operands, divisor zero included
        for (int k = 0; k < 200; k++) begin
            a = int'($urandom_range(0, 255));
            b = int'($urandom_range(0, 15));
            run_div("random", a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
